// File: rtl/iob_fifo2axis_pkg.sv
// ============================================================================
// Module   : iob_fifo2axis_pkg
// Purpose  : Shared constants, default widths and the read-credit helper for
//            the FIFO-to-AXI-Stream drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IOB_FIFO2AXIS_DATA_W
`define IOB_FIFO2AXIS_DATA_W 32
`endif
`ifndef IOB_FIFO2AXIS_LEN_W
`define IOB_FIFO2AXIS_LEN_W 16
`endif

package iob_fifo2axis_pkg;

  localparam int c_OCC_W = 2;
  localparam logic [c_OCC_W-1:0] c_OCC_FULL = 2'd2;

  // True when the buffer can still absorb one more returning word next cycle.
  function automatic logic credit_ok(input logic [c_OCC_W-1:0] occ,
                                     input logic               inflight,
                                     input logic               pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_fifo2axis_buf.sv
// ============================================================================
// Module   : iob_fifo2axis_buf
// Purpose  : Two-entry registered skid buffer holding words returned by the
//            FIFO until the stream consumer accepts them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_fifo2axis_buf
  import iob_fifo2axis_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               i_cke,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_pop,
  output logic [c_OCC_W-1:0] o_occ,
  output logic [DATA_W-1:0]  o_head
);

  logic [DATA_W-1:0]  r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [c_OCC_W-1:0] r_occ;
  logic               w_pop;

  assign w_pop = i_pop & (r_occ != '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else if (i_cke) begin
      if (i_clr) begin
        for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_occ    <= '0;
      end else begin
        if (i_push) begin
          r_mem[r_wr_ptr] <= i_data;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        case ({i_push, w_pop})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

  // The read-credit logic upstream must never overfill the buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
    (i_cke && !i_clr && i_push && !w_pop) |-> (r_occ != c_OCC_FULL));

endmodule

`default_nettype wire

// File: rtl/iob_fifo2axis.sv
// ============================================================================
// Module   : iob_fifo2axis
// Purpose  : Drains the async FIFO read port into an AXI-Stream master with
//            backpressure and per-frame tlast. Optional completed-frame
//            counter enabled by IOB_FIFO2AXIS_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_fifo2axis
  import iob_fifo2axis_pkg::*;
#(
  parameter int DATA_W = `IOB_FIFO2AXIS_DATA_W,
  parameter int LEN_W  = `IOB_FIFO2AXIS_LEN_W
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              fifo_empty_i,
  output logic              fifo_read_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  output logic              tvalid_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tlast_o,
  input  logic              tready_i
`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
  ,
  output logic [LEN_W-1:0]  frame_cnt_o
`endif
);

  logic [c_OCC_W-1:0] w_occ;
  logic               w_pop;
  logic               r_inflight;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_eff;
  logic               w_last_hit;

  iob_fifo2axis_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk    (clk_i),
    .arst_n (arst_n_i),
    .i_cke  (cke_i),
    .i_clr  (rst_i),
    .i_push (r_inflight),
    .i_data (fifo_rdata_i),
    .i_pop  (w_pop),
    .o_occ  (w_occ),
    .o_head (tdata_o)
  );

  assign tvalid_o = (w_occ != '0);
  assign w_pop    = tvalid_o & tready_i;

  // Reads are suppressed whenever the returning word could not be captured.
  assign fifo_read_o = arst_n_i & cke_i & ~rst_i & en_i & ~fifo_empty_i &
                       credit_ok(w_occ, r_inflight, w_pop);

  // The first beat of a frame sees len_i directly; later beats the latched copy.
  assign w_len_eff  = (r_beat_cnt == '0) ? len_i : r_len;
  assign w_last_hit = (w_len_eff != '0) && (r_beat_cnt == w_len_eff - LEN_W'(1));
  assign tlast_o    = tvalid_o & w_last_hit;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
      r_len      <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_inflight <= 1'b0;
        r_beat_cnt <= '0;
        r_len      <= '0;
      end else begin
        r_inflight <= fifo_read_o;
        if (r_beat_cnt == '0) r_len <= len_i;
        if (w_pop) r_beat_cnt <= tlast_o ? '0 : r_beat_cnt + LEN_W'(1);
      end
    end
  end

`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
  logic [LEN_W-1:0] r_frame_cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_frame_cnt <= '0;
    end else if (cke_i) begin
      if (rst_i) r_frame_cnt <= '0;
      else if (w_pop && tlast_o) r_frame_cnt <= r_frame_cnt + LEN_W'(1);
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_fifo2axis.sv
// ============================================================================
// Module   : tb_iob_fifo2axis
// Purpose  : Directed scoreboard bench for the FIFO-to-AXI-Stream drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_iob_fifo2axis;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              cke = 1'b1;
  logic              arst_n = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              fifo_empty;
  logic              fifo_read;
  logic [DATA_W-1:0] rdata = '0;
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready = 1'b0;
`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
  logic [LEN_W-1:0]  frame_cnt;
`endif

  iob_fifo2axis #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .arst_n_i     (arst_n),
    .rst_i        (rst),
    .en_i         (en),
    .len_i        (len),
    .fifo_empty_i (fifo_empty),
    .fifo_read_o  (fifo_read),
    .fifo_rdata_i (rdata),
    .tvalid_o     (tvalid),
    .tdata_o      (tdata),
    .tlast_o      (tlast),
    .tready_i     (tready)
`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
    ,
    .frame_cnt_o  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Source FIFO model: 1-cycle read latency, empty when all pushed words are read.
  logic [DATA_W-1:0] src [$];
  int src_cnt = 0;
  int rd_idx  = 0;
  assign fifo_empty = (rd_idx >= src_cnt);

  always @(posedge clk) begin
    if (fifo_read) begin
      rdata  <= src[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: {tlast, tdata} expected per beat, computed at push time.
  logic [DATA_W:0] exp_q [$];
  int m_cnt = 0;
  int m_len = 0;

  task automatic push_word(input logic [DATA_W-1:0] d, input int flen);
    logic last;
    if (m_cnt == 0) m_len = flen;
    last  = (m_len != 0) && (m_cnt == m_len - 1);
    m_cnt = last ? 0 : m_cnt + 1;
    src.push_back(d);
    src_cnt++;
    exp_q.push_back({last, d});
  endtask

  int first_read = -1;
  int first_valid = -1;
  int last_pop_cyc = -1;
  int n_pop = 0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (fifo_read && first_read < 0) first_read = cyc;
      if (tvalid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check("stall_tvalid", tvalid, 1'b1);
        check("stall_tdata", tdata, prev_data);
      end
      if (tvalid && tready) begin
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          check("beat_data", tdata, e[DATA_W-1:0]);
          check("beat_last", tlast, e[DATA_W]);
        end
        n_pop++;
        last_pop_cyc = cyc;
      end
      prev_stall = tvalid && !tready && !rst;
      prev_data  = tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) step(1);
    step(1);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int r0;
    int v;
`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
    logic [LEN_W-1:0] fc0;
`endif
    // Reset held with reads enabled and data available.
    en = 1'b1; tready = 1'b1; len = 16'd4;
    for (int i = 1; i <= 8; i++) push_word(DATA_W'(i), 4);
    step(3);
    check("rst_read", fifo_read, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, '0);
    check("rst_tlast", tlast, 1'b0);
    arst_n = 1'b1;
    #1;
    check("read_after_release", fifo_read, 1'b1);

    // Streaming: 8 contiguous beats, tlast on 4 and 8.
    drain("stream_drain", 50);
    check("stream_latency", first_valid - first_read, 2);
    check("stream_contiguous", last_pop_cyc - first_valid, 7);

    // Backpressure mid-stream.
    for (int i = 0; i < 10; i++) push_word(32'h100 + DATA_W'(i), 4);
    step(3);
    tready = 1'b0;
    r0 = rd_idx;
    step(5);
    check("bp_reads_le2", (rd_idx - r0) <= 2, 1'b1);
    tready = 1'b1;
    drain("bp_drain", 50);

    // FIFO runs dry mid-frame, then refills.
    for (int i = 0; i < 3; i++) push_word(32'h200 + DATA_W'(i), 4);
    drain("dry_drain1", 30);
    step(1);
    check("dry_tvalid_low", tvalid, 1'b0);
    step(4);
    for (int i = 3; i < 8; i++) push_word(32'h200 + DATA_W'(i), 4);
    drain("dry_drain2", 30);

    // Realign to a frame boundary, then change len_i in mid-frame.
    while (m_cnt != 0) push_word(32'h2F0 + DATA_W'(m_cnt), 4);
    drain("align_drain", 30);
    tready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h300 + DATA_W'(i), 4);
    for (int i = 4; i < 8; i++) push_word(32'h300 + DATA_W'(i), 2);
    step(6);
    tready = 1'b1;
    step(2);
    tready = 1'b0;
    len = 16'd2;
    step(2);
    tready = 1'b1;
    drain("lenchg_drain", 30);

    // Three frames of two beats.
`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
    fc0 = frame_cnt;
`endif
    for (int i = 0; i < 6; i++) push_word(32'h400 + DATA_W'(i), 2);
    drain("frames_drain", 30);
`ifdef IOB_FIFO2AXIS_FRAME_CNT_EN
    check("frame_cnt_delta", frame_cnt - fc0, 16'd3);
`endif

    // en_i low mid-frame: buffered and in-flight words drain, no new reads.
    tready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h500 + DATA_W'(i), 2);
    step(6);
    tready = 1'b1;
    step(1);
    en = 1'b0;
    r0 = rd_idx;
    step(6);
    check("en_low_no_reads", rd_idx - r0, 0);
    check("en_low_drained", exp_q.size(), 5);
    check("en_low_tvalid", tvalid, 1'b0);
    en = 1'b1;
    drain("en_low_drain", 30);

    // Synchronous clear discards buffered words.
    tready = 1'b0;
    push_word(32'hA5A5_0001, 2);
    push_word(32'hA5A5_0002, 2);
    step(5);
    check("pre_clr_tvalid", tvalid, 1'b1);
    en = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("clr_tvalid", tvalid, 1'b0);
    check("clr_tdata", tdata, '0);
    exp_q.delete();
    m_cnt = 0;
    en = 1'b1;
    tready = 1'b1;

    // Unframed stream: tlast never set.
    len = '0;
    v = n_pop;
    for (int i = 0; i < 300; i++) push_word(32'h1000 + DATA_W'(i), 0);
    drain("unframed_drain", 1000);
    check("unframed_count", n_pop - v, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
